// File: rtl/score_sequencer.sv
// Game score sequencer: IDLE/PLAY/OVER FSM with edge-detected collision/miss, saturating score and lives.
// Optional best-score tracking is enabled by defining SCORE_SEQUENCER_HIGHSCORE_EN.
module score_sequencer (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       collision,
  input  logic       miss,
  output logic [7:0] score,
  output logic [7:0] high_score,
  output logic [1:0] lives,
  output logic [1:0] state,
  output logic       game_over,
  output logic       score_inc
);

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    PLAY = 2'b01,
    OVER = 2'b10,
    BAD  = 2'b11
  } state_t;

  state_t     r_state;
  logic [7:0] r_score;
  logic [1:0] r_lives;
  logic       r_game_over;
  logic       r_score_inc;
  logic       r_col_q;
  logic       r_miss_q;

  logic       w_col_evt;
  logic       w_miss_evt;
  logic       w_can_inc;
  logic       w_enter_over;
  logic [7:0] w_score_final;

  assign w_col_evt     = collision & ~r_col_q;
  assign w_miss_evt    = miss & ~r_miss_q;
  assign w_can_inc     = w_col_evt && (r_score != 8'hFF);
  assign w_enter_over  = (r_state == PLAY) && w_miss_evt && (r_lives == 2'd1);
  assign w_score_final = w_can_inc ? r_score + 8'd1 : r_score;

  // NOTE: all state here uses non-blocking assignments so every register sees pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= IDLE;
      r_score     <= 8'd0;
      r_lives     <= 2'd3;
      r_game_over <= 1'b0;
      r_score_inc <= 1'b0;
      // Edge registers reset high so a level held across reset is not taken as an event.
      r_col_q     <= 1'b1;
      r_miss_q    <= 1'b1;
    end else begin
      r_col_q     <= collision;
      r_miss_q    <= miss;
      r_score_inc <= 1'b0;
      case (r_state)
        IDLE: begin
          r_score     <= 8'd0;
          r_lives     <= 2'd3;
          r_game_over <= 1'b0;
          if (start) r_state <= PLAY;
        end
        PLAY: begin
          if (w_can_inc) begin
            r_score     <= r_score + 8'd1;
            r_score_inc <= 1'b1;
          end
          if (w_miss_evt) begin
            r_lives <= r_lives - 2'd1;
            if (r_lives == 2'd1) begin
              r_state     <= OVER;
              r_game_over <= 1'b1;
            end
          end
        end
        OVER: begin
          if (start) begin
            r_state     <= PLAY;
            r_score     <= 8'd0;
            r_lives     <= 2'd3;
            r_game_over <= 1'b0;
          end
        end
        default: begin
          r_state     <= IDLE;
          r_game_over <= 1'b0;
        end
      endcase
    end
  end

`ifdef SCORE_SEQUENCER_HIGHSCORE_EN
  logic [7:0] r_high_score;

  // Compare against the final score so a last-cycle hit still counts.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_high_score <= 8'd0;
    end else if (w_enter_over && (w_score_final > r_high_score)) begin
      r_high_score <= w_score_final;
    end
  end

  assign high_score = r_high_score;
`else
  logic w_unused;
  assign w_unused   = w_enter_over ^ (^w_score_final);
  assign high_score = 8'd0;
`endif

  assign score     = r_score;
  assign lives     = r_lives;
  assign state     = r_state;
  assign game_over = r_game_over;
  assign score_inc = r_score_inc;

endmodule

// File: doc/score_sequencer.md
SCORE_SEQUENCER -- requirements
Module: score_sequencer

Interface
REQ-001 The block SHALL have port clk, input, 1 bit: the single system clock; all state changes occur on its rising edge.
REQ-002 The block SHALL have port rst, input, 1 bit: asynchronous, active-high reset.
REQ-003 The block SHALL have port start, input, 1 bit: a level request to begin a game, sampled on clk.
REQ-004 The block SHALL have port collision, input, 1 bit: a level from the game logic; a scoring hit is its rising edge.
REQ-005 The block SHALL have port miss, input, 1 bit: a level from the game logic; a lost life is its rising edge.
REQ-006 The block SHALL have port score, output, 8 bits: the current game score.
REQ-007 The block SHALL have port high_score, output, 8 bits: the best score since reset.
REQ-008 The block SHALL have port lives, output, 2 bits: the remaining lives.
REQ-009 The block SHALL have port state, output, 2 bits: the FSM state encoding.
REQ-010 The block SHALL have port game_over, output, 1 bit: high while state is OVER.
REQ-011 The block SHALL have port score_inc, output, 1 bit: a one-cycle pulse for each accepted score increment.

Function
REQ-012 The FSM SHALL have three states: IDLE = 2'b00, PLAY = 2'b01, OVER = 2'b10; the unused code 2'b11 SHALL return to IDLE on the next clk.
REQ-013 The block SHALL edge-detect collision and miss with registered previous samples, col_q and miss_q; an event is input==1 while the previous sample==0, giving exactly one event per rising edge regardless of pulse width.
REQ-014 IDLE: score SHALL be held at 0 and lives at 3; start==1 SHALL move the FSM to PLAY on the next edge.
REQ-015 PLAY: each collision event SHALL increment score by 1, visible one cycle after the event is detected, and SHALL assert score_inc for that same single cycle.
REQ-016 Score SHALL saturate at 255; a collision event at 255 SHALL leave score at 255 and SHALL NOT assert score_inc.
REQ-017 PLAY: each miss event SHALL decrement lives by 1; when lives goes from 1 to 0, the FSM SHALL enter OVER on that same edge.
REQ-018 When a collision event and the final miss event occur in the same cycle, the increment SHALL still be applied before the block freezes in OVER.
REQ-019 PLAY: start SHALL be ignored.
REQ-020 IDLE and OVER: collision and miss events SHALL be ignored, while the edge-detect registers SHALL keep sampling.
REQ-021 OVER: score and lives SHALL be frozen; start==1 SHALL move the FSM to PLAY with score cleared to 0 and lives set to 3 on that same edge.
REQ-022 game_over SHALL be a registered decode of state==OVER.

Reset
REQ-023 While rst==1 and on its assertion, regardless of clk, the block SHALL force: state=IDLE, score=0, high_score=0, lives=3, score_inc=0, game_over=0, col_q=1, miss_q=1.
REQ-024 Because the edge-detect registers reset to 1, an input held high across reset deassertion SHALL NOT produce an event.
REQ-025 Reset asserted mid-game SHALL abandon the game immediately; high_score SHALL also clear.

Configuration
REQ-026 When the macro SCORE_SEQUENCER_HIGHSCORE_EN is defined, high_score SHALL load score on the edge where the FSM enters OVER if score > high_score; ties SHALL leave high_score unchanged.
REQ-027 When SCORE_SEQUENCER_HIGHSCORE_EN is not defined, no high-score register SHALL exist and high_score SHALL be constant 0.

Verification
REQ-028 Scenario: reset, start pulse, 5 separate collision pulses of width 1-4 cycles -> score=5, exactly 5 score_inc pulses, state=PLAY.
REQ-029 Scenario: collision held high for 20 cycles in PLAY -> score increments by exactly 1.
REQ-030 Scenario: 3 miss pulses -> lives 3->2->1->0, state=OVER, game_over=1; a later collision leaves score unchanged.
REQ-031 Scenario: score driven to 255, then 2 more collisions -> score=255, no score_inc pulse.
REQ-032 Scenario (with HIGHSCORE_EN): game 1 ends at 7, then start and game 2 ends at 4 -> high_score=7; game 3 ends at 9 -> high_score=9.
REQ-033 Scenario: rst asserted mid-PLAY with score=12 and collision held high, rst released -> score=0, state=IDLE, no event from the held collision.
